// File: rtl/tt_chk_pkg.sv
// Shared types and constants for the truth-table response checker.
// The MISR constants are used only when TT_CHK_MISR_EN is defined.
package tt_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // x^16 + x^12 + x^3 + x + 1. The x^16 term is implicit in the shift.
  localparam logic [15:0] MISR_POLY    = 16'h100B;
  localparam logic [15:0] MISR_SEED    = 16'hFFFF;
  localparam int          DEFAULT_N_IN = 4;

endpackage

// File: rtl/tt_misr.sv
// 16-bit multiple-input signature register.
// It is reseeded on clr, advances on en, and is XOR-loaded with din in the low bits.
module tt_misr
  import tt_chk_pkg::*;
#(
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [15:0]   sig
);

  logic [15:0] r_sig;
  logic [15:0] w_sig_next;

  // Galois form: shift left, fold the polynomial back in on a carry-out, then absorb din.
  always_comb begin
    w_sig_next = {r_sig[14:0], 1'b0} ^ (r_sig[15] ? MISR_POLY : 16'h0000) ^ 16'(din);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_sig <= MISR_SEED;
    end else if (en) begin
      r_sig <= w_sig_next;
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/tt_resp_checker.sv
// Checks a combinational DUT's responses over an exhaustive 2^N_IN sweep against a truth table.
// Optional feature: define TT_CHK_MISR_EN to add a 16-bit MISR signature output.
module tt_resp_checker
  import tt_chk_pkg::*;
#(
  parameter int                   N_IN     = DEFAULT_N_IN,
  parameter logic [(1<<N_IN)-1:0] EXPECTED = 16'h6996
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            vec_valid,
  input  logic [N_IN-1:0] vec,
  input  logic            f,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            seq_err,
  output logic [N_IN-1:0] first_err_vec,
  output logic            first_err_valid
`ifdef TT_CHK_MISR_EN
  ,
  output logic [15:0]     signature
`endif
);

  localparam logic [N_IN-1:0] IDX_LAST = '1;
  localparam logic [N_IN:0]   ERR_MAX  = {1'b1, {N_IN{1'b0}}};

  state_t            r_state;
  logic [N_IN-1:0]   r_idx;
  logic [N_IN:0]     r_err_count;
  logic              r_seq_err;
  logic [N_IN-1:0]   r_first_err_vec;
  logic              r_first_err_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;

  logic              w_accept;
  logic              w_mismatch;
  logic              w_start_go;
  logic [N_IN:0]     w_err_next;
  logic              w_seq_next;

  always_comb begin
    w_accept   = (r_state == RUN) && vec_valid;
    w_mismatch = (f != EXPECTED[vec]);
    // A start pulse is honoured only outside RUN, so a sweep cannot be restarted mid-run.
    w_start_go = start && (r_state != RUN);
    w_err_next = r_err_count;
    if (w_accept && w_mismatch && (r_err_count != ERR_MAX)) begin
      w_err_next = r_err_count + 1'b1;
    end
    w_seq_next = r_seq_err | (w_accept && (vec != r_idx));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= IDLE;
      r_idx             <= '0;
      r_err_count       <= '0;
      r_seq_err         <= 1'b0;
      r_first_err_vec   <= '0;
      r_first_err_valid <= 1'b0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start_go) begin
            r_state           <= RUN;
            r_idx             <= '0;
            r_err_count       <= '0;
            r_seq_err         <= 1'b0;
            r_first_err_vec   <= '0;
            r_first_err_valid <= 1'b0;
            r_busy            <= 1'b1;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
          end
        end
        RUN: begin
          if (w_accept) begin
            r_err_count <= w_err_next;
            r_seq_err   <= w_seq_next;
            r_idx       <= r_idx + 1'b1;
            if (w_mismatch && !r_first_err_valid) begin
              r_first_err_vec   <= vec;
              r_first_err_valid <= 1'b1;
            end
            if (r_idx == IDX_LAST) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == '0) && !w_seq_next;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_count       = r_err_count;
  assign seq_err         = r_seq_err;
  assign first_err_vec   = r_first_err_vec;
  assign first_err_valid = r_first_err_valid;

`ifdef TT_CHK_MISR_EN
  tt_misr #(
    .DW (N_IN + 1)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (w_start_go),
    .en  (w_accept),
    .din ({f, vec}),
    .sig (signature)
  );
`endif

endmodule
